// File: rtl/reg_wb_queue_if.sv
// Bundle of producer handshake, register-file write port and forwarding lookups
// for the register write-back queue.
interface reg_wb_queue_if #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_data;

   logic                  rf_gnt;
   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;

   logic [ADDR_WIDTH-1:0] lk_addr1;
   logic                  lk_hit1;
   logic [DATA_WIDTH-1:0] lk_data1;
   logic [ADDR_WIDTH-1:0] lk_addr2;
   logic                  lk_hit2;
   logic [DATA_WIDTH-1:0] lk_data2;

   logic [CW-1:0]         count;
   logic                  empty;

   modport slave (
      input  in_valid, in_addr, in_data, rf_gnt, lk_addr1, lk_addr2,
      output in_ready, rf_wen, rf_waddr, rf_wdata,
      output lk_hit1, lk_data1, lk_hit2, lk_data2, count, empty
   );

   modport master (
      output in_valid, in_addr, in_data, rf_gnt, lk_addr1, lk_addr2,
      input  in_ready, rf_wen, rf_waddr, rf_wdata,
      input  lk_hit1, lk_data1, lk_hit2, lk_data2, count, empty
   );
endinterface

// File: rtl/reg_wb_queue.sv
// In-order write-back buffer in front of the register file write port, with
// two forwarding lookup ports that expose pending results to decode.
module reg_wb_queue #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic           clk,
   input  logic           rst,
   reg_wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]      r_valid;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   logic w_full;
   logic w_empty;
   logic w_enq;
   logic w_deq;

   assign w_full  = (r_count == C_FULL);
   assign w_empty = (r_count == '0);
   // in_ready deliberately ignores a same-cycle dequeue to keep it off the grant path
   assign w_enq   = bus.in_valid & ~w_full & (bus.in_addr != '0);
   assign w_deq   = bus.rf_gnt & ~w_empty;

   assign bus.in_ready = ~w_full;
   assign bus.empty    = w_empty;
   assign bus.count    = r_count;
   assign bus.rf_wen   = w_deq;
   assign bus.rf_waddr = r_addr[r_head];
   assign bus.rf_wdata = r_data[r_head];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_enq) begin
            r_addr[r_tail]  <= bus.in_addr;
            r_data[r_tail]  <= bus.in_data;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         // enq and deq never target the same slot: that needs empty or full
         if (w_deq) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + 1'b1;
         end else if (w_deq && !w_enq) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Walk entries oldest to youngest so the last match (youngest) wins.
   always_comb begin
      logic [PW-1:0] v_idx;
      v_idx        = '0;
      bus.lk_hit1  = 1'b0;
      bus.lk_data1 = '0;
      bus.lk_hit2  = 1'b0;
      bus.lk_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_idx = r_head + PW'(i);
         if (r_valid[v_idx] && bus.lk_addr1 != '0 && r_addr[v_idx] == bus.lk_addr1) begin
            bus.lk_hit1  = 1'b1;
            bus.lk_data1 = r_data[v_idx];
         end
         if (r_valid[v_idx] && bus.lk_addr2 != '0 && r_addr[v_idx] == bus.lk_addr2) begin
            bus.lk_hit2  = 1'b1;
            bus.lk_data2 = r_data[v_idx];
         end
      end
   end
endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, ordering, x0 drop, full/wrap,
// streaming and mid-drain reset, with hand-computed expectations.
module tb_reg_wb_queue;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   reg_wb_queue_if #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   reg_wb_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_in(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.in_valid = v;
      bus.in_addr  = a;
      bus.in_data  = d;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst          = 1'b1;
      bus.rf_gnt   = 1'b0;
      bus.lk_addr1 = 5'd5;
      bus.lk_addr2 = 5'd0;
      drive_in(1'b1, 5'd5, 32'h55);

      // reset discards the pending enqueue
      tick();
      rst = 1'b0;
      drive_in(1'b0, 5'd0, 32'h0);
      bus.rf_gnt = 1'b1;
      #1;
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_empty", 64'(bus.empty), 64'd1);
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_wen", 64'(bus.rf_wen), 64'd0);
      chk("rst_hit1", 64'(bus.lk_hit1), 64'd0);
      chk("rst_data1", 64'(bus.lk_data1), 64'd0);
      tick();
      chk("gnt_empty_count", 64'(bus.count), 64'd0);

      // three results, two to x3
      bus.rf_gnt = 1'b0;
      drive_in(1'b1, 5'd3, 32'h11);
      tick();
      drive_in(1'b1, 5'd7, 32'h22);
      bus.lk_addr2 = 5'd7;
      #1;
      chk("no_fwd_incoming", 64'(bus.lk_hit2), 64'd0);
      tick();
      drive_in(1'b1, 5'd3, 32'h33);
      tick();
      drive_in(1'b0, 5'd0, 32'h0);
      bus.lk_addr1 = 5'd3;
      #1;
      chk("q3_count", 64'(bus.count), 64'd3);
      chk("q3_hit1", 64'(bus.lk_hit1), 64'd1);
      chk("q3_data1_youngest", 64'(bus.lk_data1), 64'h33);
      chk("q3_hit2", 64'(bus.lk_hit2), 64'd1);
      chk("q3_data2", 64'(bus.lk_data2), 64'h22);
      bus.rf_gnt = 1'b1;
      #1;
      chk("drain0_wen", 64'(bus.rf_wen), 64'd1);
      chk("drain0_addr", 64'(bus.rf_waddr), 64'd3);
      chk("drain0_data", 64'(bus.rf_wdata), 64'h11);
      tick();
      chk("drain1_addr", 64'(bus.rf_waddr), 64'd7);
      chk("drain1_data", 64'(bus.rf_wdata), 64'h22);
      chk("drain1_fwd3", 64'(bus.lk_data1), 64'h33);
      tick();
      chk("drain2_wen", 64'(bus.rf_wen), 64'd1);
      chk("drain2_addr", 64'(bus.rf_waddr), 64'd3);
      chk("drain2_data", 64'(bus.rf_wdata), 64'h33);
      chk("head_write_hit", 64'(bus.lk_hit1), 64'd1);
      chk("head_write_fwd", 64'(bus.lk_data1), 64'h33);
      chk("drain2_miss2", 64'(bus.lk_hit2), 64'd0);
      tick();
      chk("drained_empty", 64'(bus.empty), 64'd1);
      chk("drained_wen", 64'(bus.rf_wen), 64'd0);
      chk("drained_hit1", 64'(bus.lk_hit1), 64'd0);
      chk("drained_data1", 64'(bus.lk_data1), 64'd0);

      // x0 handshakes but is not queued
      drive_in(1'b1, 5'd0, 32'hDEAD);
      bus.lk_addr1 = 5'd0;
      #1;
      chk("x0_ready", 64'(bus.in_ready), 64'd1);
      tick();
      drive_in(1'b0, 5'd0, 32'h0);
      #1;
      chk("x0_count", 64'(bus.count), 64'd0);
      chk("x0_wen", 64'(bus.rf_wen), 64'd0);
      chk("x0_hit1", 64'(bus.lk_hit1), 64'd0);

      // fill to full across the pointer wrap (head/tail at 3)
      bus.rf_gnt = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive_in(1'b1, 5'(k), 32'hA0 + 32'(k));
         tick();
      end
      drive_in(1'b1, 5'd9, 32'h99);
      #1;
      chk("full_count", 64'(bus.count), 64'd4);
      chk("full_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("full_reject_count", 64'(bus.count), 64'd4);
      bus.rf_gnt = 1'b1;
      #1;
      chk("full_deq_ready", 64'(bus.in_ready), 64'd0);
      chk("full_deq_addr", 64'(bus.rf_waddr), 64'd1);
      chk("full_deq_data", 64'(bus.rf_wdata), 64'hA1);
      tick();
      chk("deq_only_count", 64'(bus.count), 64'd3);
      chk("deq_only_ready", 64'(bus.in_ready), 64'd1);
      chk("deq_only_addr", 64'(bus.rf_waddr), 64'd2);
      tick();
      drive_in(1'b0, 5'd0, 32'h0);
      bus.lk_addr1 = 5'd9;
      #1;
      chk("enqdeq_count", 64'(bus.count), 64'd3);
      chk("enqdeq_addr", 64'(bus.rf_waddr), 64'd3);
      chk("enqdeq_data", 64'(bus.rf_wdata), 64'hA3);
      chk("enqdeq_fwd9", 64'(bus.lk_data1), 64'h99);
      tick();
      chk("wrap_a4", 64'(bus.rf_wdata), 64'hA4);
      tick();
      chk("wrap_9_addr", 64'(bus.rf_waddr), 64'd9);
      chk("wrap_9_data", 64'(bus.rf_wdata), 64'h99);
      tick();
      chk("wrap_empty", 64'(bus.empty), 64'd1);

      // streaming: one in, one out every cycle
      for (int k = 0; k < 10; k++) begin
         drive_in(1'b1, 5'(k + 10), 32'h1000 + 32'(k));
         #1;
         if (k == 0) begin
            chk("stream_first_wen", 64'(bus.rf_wen), 64'd0);
         end else begin
            chk("stream_wen", 64'(bus.rf_wen), 64'd1);
            chk("stream_addr", 64'(bus.rf_waddr), 64'(k + 9));
            chk("stream_data", 64'(bus.rf_wdata), 64'h1000 + 64'(k - 1));
            chk("stream_count", 64'(bus.count), 64'd1);
         end
         tick();
      end
      drive_in(1'b0, 5'd0, 32'h0);
      #1;
      chk("stream_last_addr", 64'(bus.rf_waddr), 64'd19);
      chk("stream_last_data", 64'(bus.rf_wdata), 64'h1009);
      tick();
      chk("stream_empty", 64'(bus.empty), 64'd1);

      // reset in the middle of a drain
      bus.rf_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_in(1'b1, 5'(k + 5), 32'h50 + 32'(k));
         tick();
      end
      drive_in(1'b0, 5'd0, 32'h0);
      bus.rf_gnt = 1'b1;
      #1;
      chk("mid_addr", 64'(bus.rf_waddr), 64'd5);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.lk_addr1 = 5'd6;
      #1;
      chk("midrst_wen", 64'(bus.rf_wen), 64'd0);
      chk("midrst_count", 64'(bus.count), 64'd0);
      chk("midrst_hit1", 64'(bus.lk_hit1), 64'd0);
      drive_in(1'b1, 5'd8, 32'h88);
      #1;
      chk("post_rst_no_bypass", 64'(bus.rf_wen), 64'd0);
      tick();
      drive_in(1'b0, 5'd0, 32'h0);
      #1;
      chk("post_rst_wen", 64'(bus.rf_wen), 64'd1);
      chk("post_rst_addr", 64'(bus.rf_waddr), 64'd8);
      chk("post_rst_data", 64'(bus.rf_wdata), 64'h88);
      chk("post_rst_count", 64'(bus.count), 64'd1);
      tick();
      chk("post_rst_empty", 64'(bus.empty), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-back buffer in front of the RISC-V CPU register file's single write port.
- Accepts results from execute/load units through a valid/ready handshake and queues them in order.
- Drains one entry per granted cycle into the register file write port (wen/waddr/wdata).
- Two forwarding lookup ports let decode see pending, not-yet-written values, so queued results are never lost or read stale.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- DATA_WIDTH, 32, result data width.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer presents a result.
- in_ready  output  1  queue can accept (not full).
- in_addr  input  ADDR_WIDTH  destination register.
- in_data  input  DATA_WIDTH  result value.
- rf_gnt  input  1  write port granted to this queue this cycle.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  ADDR_WIDTH  register file write address (head entry).
- rf_wdata  output  DATA_WIDTH  register file write data (head entry).
- lk_addr1  input  ADDR_WIDTH  forwarding lookup address, port 1.
- lk_hit1  output  1  port 1 matches a queued entry.
- lk_data1  output  DATA_WIDTH  newest matching queued data, port 1; 0 on miss.
- lk_addr2  input  ADDR_WIDTH  forwarding lookup address, port 2.
- lk_hit2  output  1  port 2 matches a queued entry.
- lk_data2  output  DATA_WIDTH  newest matching queued data, port 2; 0 on miss.
- count  output  clog2(DEPTH)+1  number of queued entries.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer of DEPTH {addr, data, valid} entries, with head pointer, tail pointer and count.
- Reset (rst=1 at posedge):
  - head=tail=count=0; all entry valid bits cleared.
  - Anything in flight is discarded, including a pending in_valid that same cycle.
  - Resulting outputs: in_ready=1, empty=1, rf_wen=0, lk_hit*=0, lk_data*=0.
- Enqueue (in_valid & in_ready at posedge):
  - in_addr != 0: write {in_addr, in_data} at tail, set valid, tail+1 mod DEPTH.
  - in_addr == 0 (x0): handshake completes but nothing is queued; count unchanged.
  - in_ready = (count != DEPTH). It is combinational from registered state only and does not look ahead to a same-cycle dequeue.
- Dequeue:
  - rf_wen = rf_gnt & ~empty, combinational; rf_waddr/rf_wdata always reflect the head entry.
  - At posedge with rf_wen=1: clear head valid, head+1 mod DEPTH.
  - Register file write latency is 1 cycle from rf_wen (its write happens at the same posedge).
- Simultaneous enqueue and dequeue in one cycle (non-full, non-empty): both take effect and count is unchanged. If empty, the new entry is not dequeued that cycle; minimum enqueue-to-rf_wen latency is 1 cycle.
- count updates: +1 on enqueue only, -1 on dequeue only, otherwise unchanged. Never exceeds DEPTH and never underflows.
- Forwarding (combinational, per port):
  - Scan the valid entries; an entry hits when addr == lk_addr and lk_addr != 0.
  - With several matches, the youngest (closest to tail) wins.
  - The head entry being written this cycle still counts as a hit. The register file shows the value from the next cycle.
  - Incoming in_* data is not forwarded in the same cycle.
- Ordering: entries reach the register file strictly in enqueue order, so WAW ordering is preserved.
- Pointer wrap: both pointers wrap modulo DEPTH; full/empty are decided from count, not from pointer equality.
- rf_gnt with the queue empty: no write, no state change.

Test Plan:
- Reset with in_valid=1, in_addr=5 -> next cycle count=0, empty=1, in_ready=1, rf_wen=0, lk_hit1=0 for lk_addr1=5.
- rf_gnt=0; enqueue (3,0x11), (7,0x22), (3,0x33) -> count=3; lk_addr1=3 gives hit=1, data=0x33; lk_addr2=7 gives data=0x22. Then rf_gnt=1 -> writes (3,0x11), (7,0x22), (3,0x33) on 3 consecutive cycles, then empty=1.
- Enqueue (0,0xDEAD) -> handshake completes, count stays 0, rf_wen never asserts; lk_addr1=0 gives hit=0.
- rf_gnt=0; enqueue 4 entries -> count=4, in_ready=0, and a 5th in_valid is not accepted. Assert rf_gnt=1 and in_valid together -> that cycle dequeues only, count=3; next cycle the enqueue is accepted and count=3 again (enq+deq), and the pointers wrap correctly.
- Continuous enqueue every cycle with rf_gnt=1 -> steady state count=1, 1-cycle latency, data order preserved across more than 2*DEPTH entries (pointer wrap).
- 3 entries queued, assert rst for one cycle mid-drain -> no further rf_wen, count=0, and a later enqueue/drain works normally from head=0.
